// File: rtl/dpd_sched_pkg.sv
// Shared types, constants and DPD pack/unpack helpers for the decimal converter scheduler.
package dpd_sched_pkg;

    localparam int unsigned DATA_W    = 12;
    localparam int unsigned BIN_W     = 10;
    localparam int unsigned SH_W      = DATA_W + BIN_W;
    localparam int unsigned BIN_ITERS = 10;
    localparam int unsigned CNT_W     = 4;

    localparam logic [1:0] FMT_BIN = 2'd0;
    localparam logic [1:0] FMT_BCD = 2'd1;
    localparam logic [1:0] FMT_DPD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_e;

    // Three BCD digits {d2,d1,d0} -> 10-bit DPD; digit MSBs select the row, other bits used as-is.
    function automatic logic [9:0] dpd_pack(input logic [11:0] dg);
        logic [9:0] r;
        case ({dg[11], dg[7], dg[3]})
            3'b000:  r = {dg[10:8], dg[6:4], 1'b0, dg[2:0]};
            3'b001:  r = {dg[10:8], dg[6:4], 1'b1, 2'b00, dg[0]};
            3'b010:  r = {dg[10:8], dg[2:1], dg[4], 1'b1, 2'b01, dg[0]};
            3'b100:  r = {dg[2:1], dg[8], dg[6:4], 1'b1, 2'b10, dg[0]};
            3'b110:  r = {dg[2:1], dg[8], 2'b00, dg[4], 1'b1, 2'b11, dg[0]};
            3'b101:  r = {dg[6:5], dg[8], 2'b01, dg[4], 1'b1, 2'b11, dg[0]};
            3'b011:  r = {dg[10:8], 2'b10, dg[4], 1'b1, 2'b11, dg[0]};
            default: r = {2'b00, dg[8], 2'b11, dg[4], 1'b1, 2'b11, dg[0]};
        endcase
        return r;
    endfunction

    // 10-bit DPD -> three BCD digits; bits marked don't-care in the all-large row are ignored.
    function automatic logic [11:0] dpd_unpack(input logic [9:0] p);
        logic [11:0] r;
        if (!p[3]) begin
            r = {1'b0, p[9:7], 1'b0, p[6:4], 1'b0, p[2:0]};
        end else begin
            case (p[2:1])
                2'b00:   r = {1'b0, p[9:7], 1'b0, p[6:4], 3'b100, p[0]};
                2'b01:   r = {1'b0, p[9:7], 3'b100, p[4], 1'b0, p[6:5], p[0]};
                2'b10:   r = {3'b100, p[7], 1'b0, p[6:4], 1'b0, p[9:8], p[0]};
                default: begin
                    case (p[6:5])
                        2'b00:   r = {3'b100, p[7], 3'b100, p[4], 1'b0, p[9:8], p[0]};
                        2'b01:   r = {3'b100, p[7], 1'b0, p[9:8], p[4], 3'b100, p[0]};
                        2'b10:   r = {1'b0, p[9:7], 3'b100, p[4], 3'b100, p[0]};
                        default: r = {3'b100, p[7], 3'b100, p[4], 3'b100, p[0]};
                    endcase
                end
            endcase
        end
        return r;
    endfunction

    // True when any of the three digits is outside 0..9.
    function automatic logic bcd_invalid(input logic [11:0] dg);
        return (dg[11:8] > 4'd9) || (dg[7:4] > 4'd9) || (dg[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/dpd_conv_sched_if.sv
// Request/response bundle: two requesters in, one response out.
interface dpd_conv_sched_if;
    import dpd_sched_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [1:0]        req0_ifmt;
    logic [1:0]        req0_ofmt;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [1:0]        req1_ifmt;
    logic [1:0]        req1_ofmt;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_data, req0_ifmt, req0_ofmt,
        input  req0_ready,
        output req1_valid, req1_data, req1_ifmt, req1_ofmt,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_ifmt, req0_ofmt,
        output req0_ready,
        input  req1_valid, req1_data, req1_ifmt, req1_ofmt,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: one add-3/shift step per cycle, BIN_ITERS steps per conversion.
module bin2bcd_iter
    import dpd_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [BIN_W-1:0]  bin,
    output logic [DATA_W-1:0] digits,
    output logic              done_c
);

    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  adj;
    logic [CNT_W-1:0] cnt;

    // Add 3 to every BCD digit that is 5 or more before the shift.
    always_comb begin
        adj = sh;
        for (int i = 0; i < 3; i++) begin
            if (sh[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj[BIN_W + 4*i +: 4] = sh[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= {DATA_W'(0), bin};
            cnt <= '0;
        end else if (step) begin
            sh  <= adj << 1;
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign digits = sh[SH_W-1:BIN_W];
    assign done_c = (cnt == CNT_W'(BIN_ITERS - 1));

endmodule

// File: rtl/dpd_conv_sched.sv
// Two-requester scheduler for BIN/BCD/DPD conversions over a shared iterative datapath.
// Optional feature: define DPD_SCHED_RR_EN for round-robin arbitration (default: req0 priority).
module dpd_conv_sched
    import dpd_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    dpd_conv_sched_if.slave bus,
    output logic            busy
);

    state_e            state, state_d;
    logic              idle_q, last_id, id_q, err_q, use_eng_q;
    logic [1:0]        ofmt_q;
    logic [DATA_W-1:0] dig_q;

    logic              grant, accept, eng_done_c;
    logic [DATA_W-1:0] op, eng_dig, dig;
    logic [1:0]        ifmt, ofmt;
    logic [BIN_W-1:0]  bin_red, bin_val;

    // Arbitration between the two requesters.
`ifdef DPD_SCHED_RR_EN
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ~last_id;
        else                                  grant = bus.req1_valid;
    end
`else
    logic rr_unused;
    assign rr_unused = last_id;
    always_comb begin
        grant = ~bus.req0_valid & bus.req1_valid;
    end
`endif

    // Ready only once the FSM is idle; idle_q is low through reset.
    assign bus.req0_ready = idle_q & bus.req0_valid & ~grant;
    assign bus.req1_ready = idle_q & bus.req1_valid &  grant;
    assign accept         = idle_q & (bus.req0_valid | bus.req1_valid);

    assign op      = grant ? bus.req1_data : bus.req0_data;
    assign ifmt    = grant ? bus.req1_ifmt : bus.req0_ifmt;
    assign ofmt    = grant ? bus.req1_ofmt : bus.req0_ofmt;
    assign bin_red = (op[BIN_W-1:0] >= 10'd1000) ? op[BIN_W-1:0] - 10'd1000 : op[BIN_W-1:0];

    bin2bcd_iter u_b2b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && (ifmt == FMT_BIN)),
        .step   (state == CONV),
        .bin    (bin_red),
        .digits (eng_dig),
        .done_c (eng_done_c)
    );

    // Next-state decode.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = (ifmt == FMT_BIN) ? CONV : RESP;
            CONV:    if (eng_done_c) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, status flags and per-operation context captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idle_q        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            last_id       <= 1'b1;
            id_q          <= 1'b0;
            err_q         <= 1'b0;
            use_eng_q     <= 1'b0;
            ofmt_q        <= FMT_BIN;
            dig_q         <= '0;
        end else begin
            state         <= state_d;
            idle_q        <= (state_d == IDLE);
            bus.rsp_valid <= (state_d == RESP);
            busy          <= (state_d != IDLE);
            if (accept) begin
                last_id   <= grant;
                id_q      <= grant;
                ofmt_q    <= ofmt;
                use_eng_q <= (ifmt == FMT_BIN);
                case (ifmt)
                    FMT_BIN: err_q <= 1'b0;
                    FMT_DPD: begin
                        dig_q <= dpd_unpack(op[BIN_W-1:0]);
                        err_q <= 1'b0;
                    end
                    default: begin
                        dig_q <= op;
                        err_q <= bcd_invalid(op);
                    end
                endcase
            end
        end
    end

    // Result formatting from the held digits and latched output format.
    assign dig     = use_eng_q ? eng_dig : dig_q;
    assign bin_val = BIN_W'(12'(dig[11:8]) * 12'd100 + 12'(dig[7:4]) * 12'd10 + 12'(dig[3:0]));

    always_comb begin
        case (ofmt_q)
            FMT_BIN: bus.rsp_data = {2'b00, bin_val};
            FMT_DPD: bus.rsp_data = {2'b00, dpd_pack(dig)};
            default: bus.rsp_data = dig;
        endcase
    end

    assign bus.rsp_id  = id_q;
    assign bus.rsp_err = err_q;

endmodule

// File: tb/tb_dpd_conv_sched.sv
// Directed bench for dpd_conv_sched: conversions, arbitration, stall and async reset.
module tb_dpd_conv_sched;
    import dpd_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    dpd_conv_sched_if bus();

    dpd_conv_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit port, input logic [11:0] data,
                             input logic [1:0] ifmt, input logic [1:0] ofmt);
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_data = data;
            bus.req1_ifmt  = ifmt; bus.req1_ofmt = ofmt;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_data = data;
            bus.req0_ifmt  = ifmt; bus.req0_ofmt = ofmt;
        end
    endtask

    // Wait (bounded) for the port's ready, let the accept edge pass, then drop both valids.
    task automatic accept(input bit port, input string tag);
        int   n = 0;
        logic rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = port ? bus.req1_ready : bus.req0_ready;
            n++;
        end
        chk({tag, "_acc"}, 32'(rdy), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Latency counts clock edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input string tag, input logic [11:0] exp_data, input logic exp_id,
                            input logic exp_err, input int exp_lat);
        int k = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"},  32'(k),            32'(exp_lat));
        chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        chk({tag, "_id"},   32'(bus.rsp_id),   32'(exp_id));
        chk({tag, "_err"},  32'(bus.rsp_err),  32'(exp_err));
        chk({tag, "_busy"}, 32'(busy),         32'd1);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [11:0] held;
        logic        exp_id;
        int          k;

        rst_n          = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = '0; bus.req0_ifmt = FMT_BIN; bus.req0_ofmt = FMT_BIN;
        bus.req1_valid = 1'b1; bus.req1_data = '0; bus.req1_ifmt = FMT_BIN; bus.req1_ofmt = FMT_BIN;
        bus.rsp_ready  = 1'b0;

        // Reset state with both requesters asserting valid.
        repeat (2) @(negedge clk);
        chk("rst_rdy0",  32'(bus.req0_ready), 32'd0);
        chk("rst_rdy1",  32'(bus.req1_ready), 32'd0);
        chk("rst_valid", 32'(bus.rsp_valid),  32'd0);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_data",  32'(bus.rsp_data),   32'd0);
        chk("rst_id",    32'(bus.rsp_id),     32'd0);
        chk("rst_err",   32'(bus.rsp_err),    32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single-requester conversions.
        drive_req(0, 12'd999, FMT_BIN, FMT_BCD);  accept(0, "bin999");
        wait_rsp("bin999", 12'h999, 1'b0, 1'b0, 10);

        drive_req(1, 12'd1023, FMT_BIN, FMT_BIN); accept(1, "bin1023");
        wait_rsp("bin1023", 12'd23, 1'b1, 1'b0, 10);

        drive_req(0, 12'd1000, FMT_BIN, FMT_DPD); accept(0, "bin1000");
        wait_rsp("bin1000", 12'h000, 1'b0, 1'b0, 10);

        drive_req(0, 12'h0FF, FMT_DPD, FMT_BIN);  accept(0, "dpd0ff");
        wait_rsp("dpd0ff", 12'd999, 1'b0, 1'b0, 0);

        drive_req(0, 12'h3FF, FMT_DPD, FMT_BIN);  accept(0, "dpd3ff");
        wait_rsp("dpd3ff", 12'd999, 1'b0, 1'b0, 0);

        drive_req(0, 12'h9A5, FMT_BCD, FMT_BCD);  accept(0, "bcd9a5");
        wait_rsp("bcd9a5", 12'h9A5, 1'b0, 1'b1, 0);

        drive_req(0, 12'h123, FMT_BCD, FMT_DPD);  accept(0, "bcd123");
        wait_rsp("bcd123", 12'h0A3, 1'b0, 1'b0, 0);

        drive_req(1, 12'h0A3, FMT_DPD, FMT_BCD);  accept(1, "dpd0a3");
        wait_rsp("dpd0a3", 12'h123, 1'b1, 1'b0, 0);

        // Both requesters valid continuously for three operations (last grant was req1).
        drive_req(0, 12'h111, FMT_BCD, FMT_BCD);
        drive_req(1, 12'h222, FMT_BCD, FMT_BCD);
        for (int i = 0; i < 3; i++) begin
`ifdef DPD_SCHED_RR_EN
            exp_id = (i == 1);
`else
            exp_id = 1'b0;
`endif
            k = 0;
            @(negedge clk);
            while (!bus.rsp_valid && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("arb_valid", 32'(bus.rsp_valid), 32'd1);
            chk("arb_id",    32'(bus.rsp_id),    32'(exp_id));
            chk("arb_data",  32'(bus.rsp_data),  exp_id ? 32'h222 : 32'h111);
            bus.rsp_ready = 1'b1;
            @(posedge clk); #1;
            bus.rsp_ready = 1'b0;
            if (i == 2) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end

        // Stall in RESP: result holds and nobody is accepted.
        drive_req(0, 12'd500, FMT_BIN, FMT_BCD);  accept(0, "stall");
        bus.req1_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        held = 12'h500;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.rsp_valid),  32'd1);
            chk("stall_data",  32'(bus.rsp_data),   32'(held));
            chk("stall_rdy0",  32'(bus.req0_ready), 32'd0);
            chk("stall_rdy1",  32'(bus.req1_ready), 32'd0);
        end
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready  = 1'b0;

        // Reset mid-conversion: outputs drop at once, arbitration restarts.
        drive_req(0, 12'd123, FMT_BIN, FMT_BIN);  accept(0, "midrst");
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_busy",  32'(busy),          32'd0);
        chk("midrst_data",  32'(bus.rsp_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive_req(0, 12'h321, FMT_BCD, FMT_BCD);
        drive_req(1, 12'h654, FMT_BCD, FMT_BCD);
        @(negedge clk);
        chk("postrst_rdy0", 32'(bus.req0_ready), 32'd1);
        chk("postrst_rdy1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_rsp("postrst", 12'h321, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
